// File: rtl/unidade_de_busca_pkg.sv
// pacote_busca: shared widths, halt opcode and fetch FSM states.
package pacote_busca;
  localparam int PC_W = 6;
  localparam int INSTR_W = 16;
  localparam logic [3:0] HALT_OP = 4'b1111;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} estado_t;
endpackage

// File: rtl/unidade_de_busca_fila.sv
// fila_busca: 2-entry {pc, instruction} FIFO with flush; entry 0 is always the head.
module fila_busca
  import pacote_busca::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [1:0]         ocup_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o
);
  logic [PC_W+INSTR_W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d, pos;
  always_comb begin
    pos = cnt_q - 2'(pop_i);
    e0_d = (push_i && pos == 2'd0) ? {pc_i, instr_i} : pop_i ? e1_q : e0_q;
    e1_d = (push_i && pos == 2'd1) ? {pc_i, instr_i} : e1_q;
    cnt_d = flush_i ? 2'd0 : cnt_q + 2'(push_i) - 2'(pop_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      e0_q <= '0;
      e1_q <= '0;
      cnt_q <= '0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      cnt_q <= cnt_d;
    end
  end
  assign ocup_o = cnt_q;
  assign {pc_o, instr_o} = e0_q;
endmodule

// File: rtl/unidade_de_busca.sv
// unidade_de_busca: instruction-fetch sequencer with PC, 1-cycle memory latency tracking,
// 2-entry delivery queue, branch redirect with flush and sticky halt.
module unidade_de_busca
  import pacote_busca::*;
#(
  parameter int NUM_INSTR = 42
) (
  input  logic               clk_BI,
  input  logic               reset,
  input  logic               enable,
  output logic [PC_W-1:0]    pc_mem,
  input  logic [INSTR_W-1:0] instrucao_mem,
  input  logic               desvio,
  input  logic [PC_W-1:0]    alvo_desvio,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               halted
);
  estado_t est_q, est_d;
  logic [PC_W-1:0] pc_q, pc_d, tag_q, tag_d, pc_prox;
  logic voo_q, voo_d;
  logic [1:0] ocup;
  logic pop, parada, redir, flush, push, emite;
  fila_busca u_fila (
    .clk_i  (clk_BI),
    .rst_ni (reset),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(flush),
    .pc_i   (tag_q),
    .instr_i(instrucao_mem),
    .ocup_o (ocup),
    .pc_o   (pc_instr),
    .instr_o(instr_out)
  );
  assign instr_valid = ocup != 2'd0;
  assign pop = instr_valid && instr_ready;
  assign parada = pop && instr_out[15:12] == HALT_OP;
  assign redir = (est_q == RUN || est_q == DRAIN) && desvio && !parada;
  assign flush = parada || redir;
  assign push = voo_q && !flush;
  // Issue only if the word can be guaranteed a queue slot when it returns.
  assign emite = est_q == RUN && enable && !flush &&
                 (3'(ocup) + 3'(voo_q)) < (3'd2 + 3'(pop));
  assign pc_prox = (pc_q == PC_W'(NUM_INSTR - 1)) ? '0 : pc_q + PC_W'(1);
  always_comb begin
    voo_d = emite;
    tag_d = emite ? pc_q : tag_q;
    pc_d = redir ? ((alvo_desvio >= PC_W'(NUM_INSTR)) ? '0 : alvo_desvio) :
           emite ? pc_prox : pc_q;
    case (est_q)
      IDLE:    est_d = enable ? RUN : IDLE;
      RUN:     est_d = parada ? HALT : !enable ? DRAIN : RUN;
      DRAIN:   est_d = parada ? HALT : enable ? RUN :
                       (ocup == 2'd0 && !voo_q) ? IDLE : DRAIN;
      default: est_d = HALT;
    endcase
  end
  always_ff @(posedge clk_BI or negedge reset) begin
    if (!reset) begin
      est_q <= IDLE;
      pc_q <= '0;
      tag_q <= '0;
      voo_q <= 1'b0;
    end else begin
      est_q <= est_d;
      pc_q <= pc_d;
      tag_q <= tag_d;
      voo_q <= voo_d;
    end
  end
  assign pc_mem = pc_q;
  assign halted = est_q == HALT;
endmodule

// File: tb/tb_unidade_de_busca.sv
// tb_unidade_de_busca: directed + random stimulus against an expected-PC stream scoreboard.
module tb_unidade_de_busca;
  logic clk_BI = 0, reset = 0, enable = 0, desvio = 0, instr_ready = 0;
  logic [5:0] alvo_desvio = 0, pc_mem, pc_instr;
  logic [15:0] instrucao_mem = 0, instr_out;
  logic instr_valid, halted;
  logic [15:0] mem [64];
  int checks = 0, errors = 0, exp_pc = 0, n_hs = 0, n0 = 0, saved = 0;
  logic running = 0;

  always #5 clk_BI = ~clk_BI;
  always @(posedge clk_BI) instrucao_mem <= mem[pc_mem];

  unidade_de_busca dut (
    .clk_BI(clk_BI), .reset(reset), .enable(enable), .pc_mem(pc_mem),
    .instrucao_mem(instrucao_mem), .desvio(desvio), .alvo_desvio(alvo_desvio),
    .instr_out(instr_out), .pc_instr(pc_instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: score any handshake, then apply the redirect rule to the expected stream.
  task automatic ciclo(input logic en, input logic rdy, input logic dv, input logic [5:0] alvo);
    logic halting;
    halting = 0;
    enable = en; instr_ready = rdy; desvio = dv; alvo_desvio = alvo;
    if (instr_valid && rdy) begin
      chk("hs_pc", pc_instr, exp_pc);
      chk("hs_instr", instr_out, mem[exp_pc]);
      halting = instr_out[15:12] == 4'hF;
      exp_pc = (exp_pc == 41) ? 0 : exp_pc + 1;
      n_hs++;
    end
    if (halting) running = 0;
    else if (dv && running) exp_pc = (alvo >= 42) ? 0 : int'(alvo);
    @(posedge clk_BI); #1;
    desvio = 0;
  endtask

  task automatic wait_head(input int tgt);
    for (int i = 0; i < 100; i++) begin
      if (instr_valid && pc_instr == tgt) return;
      ciclo(1, 1, 0, 0);
    end
    chk("wait_head", pc_instr, tgt);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pc_mem"}, pc_mem, 0);
    chk({tag, "_instr_out"}, instr_out, 0);
    chk({tag, "_pc_instr"}, pc_instr, 0);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_halted"}, halted, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom) & 16'hEFFF;
    repeat (3) @(posedge clk_BI);
    #1;
    chk_zero("reset");
    reset = 1;
    // start: enable seen at E, first issue at E+1, first word valid after E+2
    ciclo(1, 1, 0, 0); running = 1;
    chk("start_e_valid", instr_valid, 0); chk("start_e_pc_mem", pc_mem, 0);
    ciclo(1, 1, 0, 0);
    chk("start_e1_valid", instr_valid, 0); chk("start_e1_pc_mem", pc_mem, 1);
    ciclo(1, 1, 0, 0);
    chk("start_e2_valid", instr_valid, 1); chk("start_e2_pc", pc_instr, 0);
    for (int i = 0; i < 6; i++) begin
      chk("stream_valid", instr_valid, 1);
      ciclo(1, 1, 0, 0);
    end
    // backpressure at PC 7
    wait_head(7);
    for (int i = 0; i < 5; i++) begin
      ciclo(1, 0, 0, 0);
      chk("bp_head", pc_instr, 7); chk("bp_valid", instr_valid, 1);
    end
    chk("bp_pc_mem", pc_mem, 9);
    for (int i = 0; i < 4; i++) begin
      chk("bp_resume_valid", instr_valid, 1); chk("bp_resume_pc", pc_instr, 7 + i);
      ciclo(1, 1, 0, 0);
    end
    // redirect while 3 and 4 are buffered
    ciclo(1, 1, 1, 3);
    wait_head(3);
    ciclo(1, 0, 0, 0);
    chk("redir_buf_pc_mem", pc_mem, 5);
    ciclo(1, 0, 1, 20);
    chk("redir_r_valid", instr_valid, 0); chk("redir_r_pc_mem", pc_mem, 20);
    ciclo(1, 1, 0, 0);
    chk("redir_r1_valid", instr_valid, 0); chk("redir_r1_pc_mem", pc_mem, 21);
    ciclo(1, 1, 0, 0);
    chk("redir_r2_valid", instr_valid, 1); chk("redir_r2_pc", pc_instr, 20);
    repeat (3) ciclo(1, 1, 0, 0);
    ciclo(1, 1, 1, 50);
    ciclo(1, 1, 0, 0);
    ciclo(1, 1, 0, 0);
    chk("redir_big_valid", instr_valid, 1); chk("redir_big_pc", pc_instr, 0);
    // wrap 40, 41, 0, 1
    ciclo(1, 1, 1, 40);
    n0 = n_hs;
    repeat (6) ciclo(1, 1, 0, 0);
    chk("wrap_count", n_hs - n0, 4);
    chk("wrap_next", pc_instr, 2);
    // drain with 2 buffered, then re-enable
    ciclo(1, 0, 0, 0);
    ciclo(0, 0, 0, 0);
    chk("drain_head", pc_instr, 2);
    ciclo(0, 1, 0, 0);
    ciclo(0, 1, 0, 0);
    saved = exp_pc;
    chk("drain_saved", saved, 4);
    for (int i = 0; i < 3; i++) begin
      chk("drain_empty", instr_valid, 0); chk("drain_pc_mem", pc_mem, saved);
      ciclo(0, 1, 0, 0);
    end
    ciclo(1, 1, 0, 0);
    ciclo(1, 1, 0, 0);
    ciclo(1, 1, 0, 0);
    chk("reen_valid", instr_valid, 1); chk("reen_pc", pc_instr, saved);
    // random backpressure and redirects
    for (int i = 0; i < 300; i++)
      ciclo(1, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 6'($urandom_range(0, 63)));
    // asynchronous reset mid-run
    #3 reset = 0;
    #1 chk_zero("async");
    @(posedge clk_BI); #1;
    reset = 1; running = 0; exp_pc = 0;
    // halt on word 5, same-cycle redirect ignored
    mem[5] = 16'hF000;
    ciclo(1, 1, 0, 0); running = 1;
    wait_head(5);
    chk("halt_pre", halted, 0);
    ciclo(1, 1, 1, 30);
    for (int i = 0; i < 4; i++) begin
      chk("halt_flag", halted, 1); chk("halt_valid", instr_valid, 0);
      chk("halt_pc_mem", pc_mem, 7);
      ciclo(1, 1, i == 1, 10);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
